ex_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit inside the EX stage, fed directly by the id_ex pipeline register.
//  - Takes an M-extension op (funct3) plus operands, computes the result over 32 iterations.
//  - Holds the pipeline via stallreq_o while busy; on completion hands result, wd and wreg to the ex_mem path.
//  - Branch flush (ex_b_flag) cancels an in-flight operation.

---
 rtl/ex_muldiv.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with pipeline stall and branch-flush handling.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       op_q;
  logic [4:0]       wd_q;
  logic             wreg_q;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  opb;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic is_neg);
    return is_neg ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   s1_signed;
  logic                   s2_signed;
  logic                   sgn1;
  logic                   sgn2;
  logic                   div_zero;
  logic                   div_ovf;
  logic                   special;
  logic [XLEN-1:0]        special_res;

  assign rs1_s     = rs1_i;
  assign rs2_s     = rs2_i;
  // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 is also unsigned for MULHSU
  assign s1_signed = !(op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
  assign s2_signed = s1_signed && (op_i != 3'd2);
  assign sgn1      = s1_signed && rs1_i[XLEN-1];
  assign sgn2      = s2_signed && rs2_i[XLEN-1];

  assign div_zero    = op_i[2] && (rs2_i == '0);
  assign div_ovf     = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);

  assign stallreq_o = !rst && !flush_i && ((state == BUSY) || (state == IDLE && start_i));

  // One iteration step for each algorithm
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_n;
  logic [XLEN-1:0] mul_lo_n;
  logic [XLEN:0]   div_trial;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] div_hi_n;
  logic [XLEN-1:0] div_lo_n;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_n  = mul_sum[XLEN:1];
  assign mul_lo_n  = {mul_sum[0], acc_lo[XLEN-1:1]};
  assign div_trial = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, opb};
  assign div_hi_n  = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_lo_n  = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod = fix_wide({mul_hi_n, mul_lo_n}, neg_q);
    if (op_q[2])
      final_res = op_q[1] ? fix_word(div_hi_n, neg_r) : fix_word(div_lo_n, neg_q);
    else if (op_q[1:0] == 2'b00)
      final_res = prod[XLEN-1:0];
    else
      final_res = prod[2*XLEN-1:XLEN];
  end

  // Datapath registers: acc_hi is product-high / partial remainder, acc_lo is multiplier / quotient
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      op_q   <= op_i;
      wd_q   <= wd_i;
      wreg_q <= wreg_i;
      neg_q  <= sgn1 ^ sgn2;
      neg_r  <= sgn1;
      acc_hi <= '0;
      acc_lo <= mag(rs1_s, sgn1);
      opb    <= mag(rs2_s, sgn2);
    end else if (state == BUSY) begin
      acc_hi <= op_q[2] ? div_hi_n : mul_hi_n;
      acc_lo <= op_q[2] ? div_lo_n : mul_lo_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
      wd_o     <= '0;
      wreg_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (special) begin
                state    <= DONE;
                done_o   <= 1'b1;
                result_o <= special_res;
                wd_o     <= wd_i;
                wreg_o   <= wreg_i;
              end else begin
                state <= BUSY;
                cnt   <= CNT_W'(XLEN-1);
              end
            end
          end
          BUSY: begin
            if (cnt == '0) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= final_res;
              wd_o     <= wd_q;
              wreg_o   <= wreg_q;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results queued at start, compared on done_o.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  wd_o;
  logic        wreg_o;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .done_o(done_o), .result_o(result_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result_o, mon_e.res);
        check("wd",     wd_o,     mon_e.wd);
        check("wreg",   wreg_o,   mon_e.wreg);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr, input int exp_lat, input string tag);
    int   lat;
    int   stall_low;
    exp_t e;
    @(negedge clk);
    op_i = op; rs1_i = a; rs2_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
    e.res = ref_op(op, a, b); e.wd = wd; e.wreg = wr;
    exp_q.push_back(e);
    #1 check({tag, "_stall_start"}, stallreq_o, 1);
    lat = 0;
    stall_low = 0;
    do begin
      @(negedge clk);
      if (!done_o && !stallreq_o) stall_low++;
      start_i = 1'b0;
      lat++;
    end while (!done_o && lat < 40);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_busy"}, stall_low, 0);
    check({tag, "_stall_done"}, stallreq_o, 0);
    if (!done_o && exp_q.size() > 0) void'(exp_q.pop_back());
    last_res = e.res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rlat;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    rs1_i = '0; rs2_i = '0; wd_i = '0; wreg_i = 1'b0; last_res = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result_o, 0);
    check("rst_wd", wd_o, 0);
    check("rst_wreg", wreg_o, 0);
    check("rst_done", done_o, 0);
    check("rst_stall", stallreq_o, 0);
    rst = 1'b0;

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  1'b1, 33, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  1'b1, 33, "mulh");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3,  1'b0, 33, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  1'b1, 33, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  1'b1, 33, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  1'b1, 33, "rem");
    run_op(3'd5, 32'd100,       32'd7,         5'd7,  1'b1, 33, "divu");
    run_op(3'd7, 32'd100,       32'd7,         5'd8,  1'b1, 33, "remu");
    run_op(3'd5, 32'h1234,      32'd0,         5'd9,  1'b1, 1,  "divu_zero");
    run_op(3'd7, 32'h1234,      32'd0,         5'd10, 1'b1, 1,  "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1,  "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, 1,  "rem_ovf");
    run_op(3'd4, 32'h55,        32'd0,         5'd13, 1'b1, 1,  "div_zero");

    // Flush in the 10th BUSY cycle: nothing may complete
    @(negedge clk);
    op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; wd_i = 5'd20; wreg_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1 check("flush_stall", stallreq_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_idle_stall", stallreq_o, 0);
    check("flush_done", done_o, 0);
    check("flush_result_hold", result_o, last_res);
    repeat (40) @(negedge clk);
    run_op(3'd4, 32'd1000, 32'd3, 5'd21, 1'b1, 33, "div_after_flush");

    // Reset in the 5th BUSY cycle
    @(negedge clk);
    op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; wd_i = 5'd22; wreg_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_result", result_o, 0);
    check("midrst_wd", wd_o, 0);
    check("midrst_wreg", wreg_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_stall", stallreq_o, 0);
    last_res = '0;
    repeat (40) @(negedge clk);

    // Back-to-back starts, each in the IDLE cycle after DONE
    run_op(3'd0, 32'd12345,     32'd678,       5'd23, 1'b1, 33, "b2b_mul");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd16,        5'd24, 1'b1, 33, "b2b_divu");
    run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd25, 1'b0, 33, "b2b_mulh");

    for (int i = 0; i < 12; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = (i % 4 == 0) ? 32'd0 : $urandom;
      rlat = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33;
      run_op(rop, ra, rb, 5'(i), 1'(i % 2), rlat, "rand");
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
